// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and a future transmitter.
//   - uart_state_e   : deframing FSM state encoding
//   - OVERSAMPLE     : baud ticks per bit period
//   - MID_START      : sample count at which the start bit is re-checked
//   - LAST_SAMPLE    : sample count at which data/parity/stop bits are taken
//   - parity_mismatch: 1 when the received parity bit disagrees with the mode
package uart_pkg;

    localparam int         OVERSAMPLE  = 8;
    localparam logic [2:0] MID_START   = 3'd3;
    localparam logic [2:0] LAST_SAMPLE = 3'd7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Even mode expects XOR(data, pbit) = 0, odd mode expects 1.
    function automatic logic parity_mismatch(input logic [7:0] data,
                                             input logic       pbit,
                                             input logic       odd);
        return (^data) ^ pbit ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: input conditioning for uart_rx.
//   clk, reset : system clock, asynchronous active-high reset
//   baud_rx    : oversample square wave (synchronous to clk)
//   rx         : asynchronous serial line, idle high
//   rx_s       : rx after a 2-flop synchroniser
//   tick       : one-clk pulse on each rising edge of baud_rx
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic baud_rx,
    input  logic rx,
    output logic rx_s,
    output logic tick
);

    logic [1:0] rx_sync_q, rx_sync_d;
    logic       baud_q, baud_d;

    always_comb begin
        rx_sync_d = {rx_sync_q[0], rx};
        baud_d    = baud_rx;
    end

    // Synchroniser resets to the idle-high line level so no false start
    // is seen coming out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync_q <= 2'b11;
            baud_q    <= 1'b0;
        end else begin
            rx_sync_q <= rx_sync_d;
            baud_q    <= baud_d;
        end
    end

    assign rx_s = rx_sync_q[1];
    assign tick = baud_rx & ~baud_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (1 start, 8 data LSB first, optional
// parity, 1 stop) with valid/ack host handshake.
//   clk, reset            : system clock, asynchronous active-high reset
//   baud_rx               : OVERSAMPLE ticks per bit (rising edges)
//   rx                    : serial line, idle high
//   parity_en, parity_odd : frame format, latched at start detection
//   data_out, data_valid  : received byte, held until data_ack
//   data_ack              : host consumes the byte
//   parity_err, frame_err : status of the byte in data_out
//   overrun               : sticky, a byte was overwritten before ack
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_rx,
    input  logic                 rx,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ack,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW = $clog2(OVERSAMPLE);

    logic rx_s, tick;

    uart_rx_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .baud_rx (baud_rx),
        .rx      (rx),
        .rx_s    (rx_s),
        .tick    (tick)
    );

    uart_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           bidx_q, bidx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 cfg_pen_q, cfg_pen_d;
    logic                 cfg_podd_q, cfg_podd_d;
    logic                 pmis_q, pmis_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bidx_d       = bidx_q;
        shreg_d      = shreg_q;
        cfg_pen_d    = cfg_pen_q;
        cfg_podd_d   = cfg_podd_q;
        pmis_d       = pmis_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;

        if (data_ack && data_valid_q) begin
            data_valid_d = 1'b0;
            overrun_d    = 1'b0;
        end

        if (tick) begin
            cnt_d = cnt_q + 1'b1;
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d    = START;
                        cfg_pen_d  = parity_en;
                        cfg_podd_d = parity_odd;
                    end
                end
                START: begin
                    if (cnt_q == CW'(MID_START)) begin
                        cnt_d = '0;
                        if (rx_s) begin
                            state_d = IDLE;   // glitch, not a real start bit
                        end else begin
                            bidx_d  = '0;
                            state_d = DATA;
                        end
                    end
                end
                DATA: begin
                    if (cnt_q == CW'(LAST_SAMPLE)) begin
                        shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                        bidx_d  = bidx_q + 1'b1;
                        if (bidx_q == 3'(DATA_BITS - 1))
                            state_d = cfg_pen_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (cnt_q == CW'(LAST_SAMPLE)) begin
                        pmis_d  = parity_mismatch(shreg_q, rx_s, cfg_podd_q);
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (cnt_q == CW'(LAST_SAMPLE)) begin
                        data_out_d   = shreg_q;
                        data_valid_d = 1'b1;
                        frame_err_d  = ~rx_s;
                        parity_err_d = cfg_pen_q & pmis_q;
                        // An ack in this same cycle consumes the old byte,
                        // so the new one replaces it without an overrun.
                        if (data_valid_q && !data_ack)
                            overrun_d = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bidx_q       <= '0;
            shreg_q      <= '0;
            cfg_pen_q    <= 1'b0;
            cfg_podd_q   <= 1'b0;
            pmis_q       <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bidx_q       <= bidx_d;
            shreg_q      <= shreg_d;
            cfg_pen_q    <= cfg_pen_d;
            cfg_podd_q   <= cfg_podd_d;
            pmis_q       <= pmis_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. baud_rx toggles every 2 clk, so a
// bit lasts 32 clk. All stimulus is advanced one negedge at a time by step().
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset, baud_rx, rx, parity_en, parity_odd, data_ack;
    logic [7:0] data_out;
    logic       data_valid, parity_err, frame_err, overrun;

    int n_chk = 0;
    int n_err = 0;
    int ph    = 0;

    always #5 clk = ~clk;

    uart_rx dut (
        .clk        (clk),
        .reset      (reset),
        .baud_rx    (baud_rx),
        .rx         (rx),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    typedef struct {
        logic [7:0] data;
        bit         pen, podd, pbit, stop;
        logic [7:0] exp_data;
        bit         exp_perr, exp_ferr;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next negedge; baud_rx rises whenever ph becomes 2,
    // making the following posedge a tick.
    task automatic step();
        @(negedge clk);
        ph      = (ph + 1) % 4;
        baud_rx = (ph >= 2);
    endtask

    task automatic ack_pulse();
        data_ack = 1'b1;
        step();
        data_ack = 1'b0;
    endtask

    // Sends one frame aligned to a baud_rx rising edge, followed by two idle
    // bit times. With that alignment the stop (last) bit is sampled on the
    // posedge right after step (nb-1)*32+20, so ack_del raises data_ack for
    // exactly that clk. abort_at >= 0 returns early at that step.
    task automatic send_frame(input logic [7:0] d, input bit pen, input bit podd,
                              input bit pbit, input bit stop, input bit ack_del,
                              input int abort_at);
        logic [10:0] fb;
        int          nb, del_s;
        fb         = '1;
        fb[0]      = 1'b0;
        fb[8:1]    = d;
        if (pen) begin
            fb[9]  = pbit;
            fb[10] = stop;
            nb     = 11;
        end else begin
            fb[9]  = stop;
            nb     = 10;
        end
        del_s      = (nb - 1) * 32 + 20;
        parity_en  = pen;
        parity_odd = podd;
        do step(); while (ph != 2);
        for (int s = 0; s < nb * 32 + 64; s++) begin
            if (s > 0) step();
            if (abort_at >= 0 && s == abort_at) return;
            rx = (s < nb * 32) ? fb[s / 32] : 1'b1;
            if (ack_del) data_ack = (s == del_s);
        end
        data_ack = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"},  {24'd0, data_out}, 32'h0);
        chk({tag, "_valid"}, {31'd0, data_valid}, 32'h0);
        chk({tag, "_perr"},  {31'd0, parity_err}, 32'h0);
        chk({tag, "_ferr"},  {31'd0, frame_err}, 32'h0);
        chk({tag, "_ovr"},   {31'd0, overrun}, 32'h0);
    endtask

    initial begin
        //           data   pen podd pbit stop exp_data perr ferr
        tbl[0] = '{8'hA5, 0, 0, 0, 1, 8'hA5, 0, 0};
        tbl[1] = '{8'h07, 1, 0, 1, 1, 8'h07, 0, 0};
        tbl[2] = '{8'h07, 1, 1, 1, 1, 8'h07, 1, 0};
        tbl[3] = '{8'hFF, 0, 0, 0, 0, 8'hFF, 0, 1};
        tbl[4] = '{8'h00, 1, 1, 0, 1, 8'h00, 1, 0};
        tbl[5] = '{8'h81, 1, 0, 0, 1, 8'h81, 0, 0};

        reset = 1'b1; baud_rx = 1'b0; rx = 1'b1;
        parity_en = 1'b0; parity_odd = 1'b0; data_ack = 1'b0;
        repeat (4) step();
        chk_all_zero("reset");
        reset = 1'b0;
        repeat (8) step();

        foreach (tbl[i]) begin
            send_frame(tbl[i].data, tbl[i].pen, tbl[i].podd, tbl[i].pbit,
                       tbl[i].stop, 1'b0, -1);
            chk($sformatf("v%0d_data", i), {24'd0, data_out}, {24'd0, tbl[i].exp_data});
            chk($sformatf("v%0d_valid", i), {31'd0, data_valid}, 32'd1);
            chk($sformatf("v%0d_perr", i), {31'd0, parity_err}, {31'd0, tbl[i].exp_perr});
            chk($sformatf("v%0d_ferr", i), {31'd0, frame_err}, {31'd0, tbl[i].exp_ferr});
            chk($sformatf("v%0d_ovr", i), {31'd0, overrun}, 32'd0);
            ack_pulse();
            chk($sformatf("v%0d_ack", i), {31'd0, data_valid}, 32'd0);
            step();
            chk($sformatf("v%0d_ack_hold", i), {31'd0, data_valid}, 32'd0);
        end

        // Glitch: rx low for 2 ticks only.
        parity_en = 1'b0;
        do step(); while (ph != 2);
        rx = 1'b0;
        repeat (8) step();
        rx = 1'b1;
        repeat (96) step();
        chk("glitch_valid", {31'd0, data_valid}, 32'd0);
        send_frame(8'h3C, 0, 0, 0, 1, 1'b0, -1);
        chk("post_glitch_data", {24'd0, data_out}, 32'h3C);
        chk("post_glitch_valid", {31'd0, data_valid}, 32'd1);
        chk("post_glitch_ferr", {31'd0, frame_err}, 32'd0);
        ack_pulse();

        // Overrun: two frames without ack.
        send_frame(8'h11, 0, 0, 0, 1, 1'b0, -1);
        chk("ovr_first", {31'd0, overrun}, 32'd0);
        send_frame(8'h22, 0, 0, 0, 1, 1'b0, -1);
        chk("ovr_data", {24'd0, data_out}, 32'h22);
        chk("ovr_valid", {31'd0, data_valid}, 32'd1);
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        ack_pulse();
        chk("ovr_ack_valid", {31'd0, data_valid}, 32'd0);
        chk("ovr_ack_clear", {31'd0, overrun}, 32'd0);

        // Ack in the exact delivery cycle of the second byte.
        send_frame(8'h33, 0, 0, 0, 1, 1'b0, -1);
        chk("sim_first", {24'd0, data_out}, 32'h33);
        send_frame(8'h44, 0, 0, 0, 1, 1'b1, -1);
        chk("sim_data", {24'd0, data_out}, 32'h44);
        chk("sim_valid", {31'd0, data_valid}, 32'd1);
        chk("sim_ovr", {31'd0, overrun}, 32'd0);

        // Reset during data bit 4 of 0x55, with 0x44 still pending.
        send_frame(8'h55, 0, 0, 0, 1, 1'b0, 170);
        rx    = 1'b1;
        reset = 1'b1;
        step();
        chk_all_zero("midrst");
        step();
        reset = 1'b0;
        repeat (400) step();
        chk("midrst_after_valid", {31'd0, data_valid}, 32'd0);
        chk("midrst_after_data", {24'd0, data_out}, 32'h0);
        send_frame(8'h81, 0, 0, 0, 1, 1'b0, -1);
        chk("post_rst_data", {24'd0, data_out}, 32'h81);
        chk("post_rst_valid", {31'd0, data_valid}, 32'd1);
        chk("post_rst_ferr", {31'd0, frame_err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
